// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
//
// Data-memory responder for the MIPS data bus. A load/store request is accepted
// in IDLE and its address, direction and data are captured. The block then
// waits LATENCY cycles and completes the access with a one-cycle `ready` pulse.
// It also includes a write checker. The checker raises sticky pass/fail flags
// and counts committed stores, so test status is visible on the board.
//
// Ports
//   clk       system clock, all state on the rising edge
//   reset     asynchronous active-low reset (0 = in reset)
//   req       request valid, held by the initiator until `ready`
//   we        1 = store, 0 = load (captured at acceptance)
//   addr      byte address, bits [1:0] ignored for indexing
//   wdata     store data (captured at acceptance)
//   rdata     load data, valid only in the `ready` cycle (0 otherwise)
//   ready     one-cycle completion pulse
//   err       sticky: an out-of-range access was completed
//   pass      sticky: PASS_DATA stored to PASS_ADDR
//   fail      sticky: any other store committed outside IGNORE_ADDR
//   wr_count  committed in-range store count, saturating at 16'hFFFF
// -----------------------------------------------------------------------------
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 64,
  parameter int unsigned LATENCY     = 2,
  parameter logic [31:0] PASS_ADDR   = 32'd84,
  parameter logic [31:0] PASS_DATA   = 32'd7,
  parameter logic [31:0] IGNORE_ADDR = 32'd80
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        err,
  output logic        pass,
  output logic        fail,
  output logic [15:0] wr_count
);

  localparam int unsigned AW   = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  LAT4 = 4'(LATENCY);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;

  logic [31:0] ram [DEPTH_WORDS];

  // The RESP entry can happen directly from IDLE when LATENCY is 0. In that
  // case the access is still being captured, so the live inputs are used.
  // Otherwise the captured copies are used.
  logic [31:0]   acc_addr;
  logic          acc_we;
  logic          acc_in_range;
  logic [AW-1:0] acc_idx;
  logic [31:0]   resp_rdata;
  logic          q_in_range;
  logic [AW-1:0] q_idx;

  // NOTE: every signal driven here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    acc_addr     = addr_q;
    acc_we       = we_q;
    if (state == IDLE) begin
      acc_addr = addr;
      acc_we   = we;
    end
    acc_idx      = acc_addr[AW+1:2];
    acc_in_range = (acc_addr[31:AW+2] == '0);
    resp_rdata   = '0;
    if (!acc_we && acc_in_range) resp_rdata = ram[acc_idx];

    q_idx        = addr_q[AW+1:2];
    q_in_range   = (addr_q[31:AW+2] == '0);
  end

  // NOTE: sequential state uses non-blocking assignments only. All registers
  // then update together at the edge, so ordering inside the block cannot
  // create a race.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata    <= '0;
      ready    <= 1'b0;
      err      <= 1'b0;
      pass     <= 1'b0;
      fail     <= 1'b0;
      wr_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            we_q    <= we;
            addr_q  <= addr;
            wdata_q <= wdata;
            cnt     <= LAT4;
            if (LAT4 == 4'd0) begin
              state <= RESP;
              ready <= 1'b1;
              rdata <= resp_rdata;
              if (!acc_in_range) err <= 1'b1;
            end else begin
              state <= WAIT;
            end
          end
        end

        WAIT: begin
          // A dropped request abandons the access without side effects.
          if (!req) begin
            state <= IDLE;
          end else if (cnt == 4'd1) begin
            state <= RESP;
            ready <= 1'b1;
            rdata <= resp_rdata;
            if (!acc_in_range) err <= 1'b1;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end

        RESP: begin
          // Exactly one cycle long. A req still high here is the old request,
          // so the FSM always goes back through IDLE.
          state <= IDLE;
          ready <= 1'b0;
          rdata <= '0;
          if (we_q && q_in_range) begin
            if (addr_q == PASS_ADDR && wdata_q == PASS_DATA) pass <= 1'b1;
            else if (addr_q != IGNORE_ADDR)                  fail <= 1'b1;
            if (wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: the RAM array has no reset. Its contents must survive reset, and an
  // unreset array maps onto plain RAM primitives. A reset asserted during RESP
  // forces state to IDLE, which discards the pending write.
  always_ff @(posedge clk) begin
    if (state == RESP && we_q && q_in_range) ram[q_idx] <= wdata_q;
  end

endmodule

// File: tb/tb_dmem_responder.sv
// -----------------------------------------------------------------------------
// tb_dmem_responder
//
// Directed bench for dmem_responder. Two instances are built, one with
// LATENCY=2 and one with LATENCY=0. The same suite runs on each in turn.
// `sel` picks which instance sees `req` and whose outputs are observed.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        sel;

  logic [31:0] rdata_a, rdata_b, rdata;
  logic        ready_a, ready_b, ready;
  logic        err_a, err_b, err;
  logic        pass_a, pass_b, pass;
  logic        fail_a, fail_b, fail;
  logic [15:0] wrc_a, wrc_b, wr_count;

  int n_tests = 0;
  int n_fail  = 0;
  int lat     = 2;

  always #5 clk = ~clk;

  dmem_responder #(.LATENCY(2)) dut_lat2 (
    .clk(clk), .reset(reset), .req(req & ~sel), .we(we), .addr(addr),
    .wdata(wdata), .rdata(rdata_a), .ready(ready_a), .err(err_a),
    .pass(pass_a), .fail(fail_a), .wr_count(wrc_a)
  );

  dmem_responder #(.LATENCY(0)) dut_lat0 (
    .clk(clk), .reset(reset), .req(req & sel), .we(we), .addr(addr),
    .wdata(wdata), .rdata(rdata_b), .ready(ready_b), .err(err_b),
    .pass(pass_b), .fail(fail_b), .wr_count(wrc_b)
  );

  always_comb begin
    rdata    = sel ? rdata_b : rdata_a;
    ready    = sel ? ready_b : ready_a;
    err      = sel ? err_b   : err_a;
    pass     = sel ? pass_b  : pass_a;
    fail     = sel ? fail_b  : fail_a;
    wr_count = sel ? wrc_b   : wrc_a;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL L%0d %s: got %0h expected %0h", lat, tag, got, exp);
    end
  endtask

  task automatic check_flags(input string tag, input logic p, input logic f,
                             input logic e, input logic [15:0] wc);
    check({tag, "_pass"}, 32'(pass), 32'(p));
    check({tag, "_fail"}, 32'(fail), 32'(f));
    check({tag, "_err"},  32'(err),  32'(e));
    check({tag, "_wrc"},  32'(wr_count), 32'(wc));
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0; req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    #1;
    check("rst_rdata", rdata, 32'h0);
    check("rst_ready", 32'(ready), 32'h0);
    check_flags("rst", 1'b0, 1'b0, 1'b0, 16'd0);
    @(negedge clk);
    reset = 1'b1;
  endtask

  // One complete access. Cycles are counted from the accepting edge
  // (inclusive) up to the edge after which ready is seen high.
  task automatic access(input string tag, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input bit scramble,
                        output logic [31:0] rd);
    int  cyc;
    bit  got;
    cyc = 0; got = 1'b0; rd = 'x;
    @(negedge clk);
    req = 1'b1; we = w; addr = a; wdata = d;
    for (int i = 0; i < 40 && !got; i++) begin
      @(posedge clk); #1;
      cyc++;
      if (ready) begin
        got = 1'b1;
        rd  = rdata;
      end else if (scramble) begin
        we = ~w; addr = a ^ 32'h4; wdata = ~d;
      end
    end
    req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    check({tag, "_seen_ready"}, 32'(got), 32'h1);
    check({tag, "_latency"}, 32'(cyc), 32'(lat + 1));
    @(posedge clk); #1;
    check({tag, "_ready_1cyc"}, 32'(ready), 32'h0);
  endtask

  task automatic run_suite();
    logic [31:0] rd;
    bit          seen;

    do_reset();

    access("st84_7", 1'b1, 32'd84, 32'd7, 1'b0, rd);
    check("st84_7_rdata", rd, 32'h0);
    check_flags("st84_7", 1'b1, 1'b0, 1'b0, 16'd1);

    access("st80", 1'b1, 32'd80, 32'h1234, 1'b1, rd);
    check_flags("st80", 1'b1, 1'b0, 1'b0, 16'd2);
    access("ld80", 1'b0, 32'd80, 32'h0, 1'b0, rd);
    check("ld80_rdata", rd, 32'h0000_1234);
    check_flags("ld80", 1'b1, 1'b0, 1'b0, 16'd2);
    access("ld87", 1'b0, 32'd87, 32'h0, 1'b0, rd);
    check("ld87_rdata", rd, 32'd7);

    // RAM survives reset, flags do not.
    do_reset();
    access("oor_ld", 1'b0, 32'h400, 32'h0, 1'b0, rd);
    check("oor_ld_rdata", rd, 32'h0);
    check_flags("oor_ld", 1'b0, 1'b0, 1'b1, 16'd0);
    access("oor_st_pass", 1'b1, 32'h454, 32'd7, 1'b0, rd);
    check_flags("oor_st_pass", 1'b0, 1'b0, 1'b1, 16'd0);
    access("oor_st_alias", 1'b1, 32'h450, 32'h55, 1'b0, rd);
    check_flags("oor_st_alias", 1'b0, 1'b0, 1'b1, 16'd0);
    access("ld80_after_oor", 1'b0, 32'd80, 32'h0, 1'b0, rd);
    check("ld80_after_oor_rdata", rd, 32'h0000_1234);

    access("st84_5", 1'b1, 32'd84, 32'd5, 1'b0, rd);
    check_flags("st84_5", 1'b0, 1'b1, 1'b1, 16'd1);
    access("st84_7b", 1'b1, 32'd84, 32'd7, 1'b0, rd);
    check_flags("st84_7b", 1'b1, 1'b1, 1'b1, 16'd2);
    access("st40", 1'b1, 32'd40, 32'h99, 1'b0, rd);
    check_flags("st40", 1'b1, 1'b1, 1'b1, 16'd3);

    if (lat > 0) begin
      // Abort: request withdrawn while waiting.
      @(negedge clk);
      req = 1'b1; we = 1'b1; addr = 32'd40; wdata = 32'hDEAD;
      @(posedge clk); #1;
      @(negedge clk);
      req = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 6; i++) begin
        @(posedge clk); #1;
        if (ready) seen = 1'b1;
      end
      check("abort_no_ready", 32'(seen), 32'h0);
      check("abort_wrc", 32'(wr_count), 32'd3);
      access("ld40", 1'b0, 32'd40, 32'h0, 1'b0, rd);
      check("ld40_rdata", rd, 32'h99);

      // Reset while waiting on a store to 84.
      @(negedge clk);
      req = 1'b1; we = 1'b1; addr = 32'd84; wdata = 32'hBEEF;
      @(posedge clk); #1;
      reset = 1'b0;
      #1;
      check("midrst_ready", 32'(ready), 32'h0);
      check("midrst_rdata", rdata, 32'h0);
      check_flags("midrst", 1'b0, 1'b0, 1'b0, 16'd0);
      @(negedge clk);
      req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
      reset = 1'b1;
      access("ld84_after_rst", 1'b0, 32'd84, 32'h0, 1'b0, rd);
      check("ld84_after_rst_rdata", rd, 32'd7);
      check_flags("ld84_after_rst", 1'b0, 1'b0, 1'b0, 16'd0);
    end
  endtask

  initial begin
    reset = 1'b0; req = 1'b0; we = 1'b0; addr = '0; wdata = '0; sel = 1'b0;
    repeat (2) @(posedge clk);

    sel = 1'b0; lat = 2;
    run_suite();

    sel = 1'b1; lat = 0;
    run_suite();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
